// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, debouncer, edge pulses and press-stepped rate select
// Optional long-press detection is compiled in with `define LONG_PRESS_EN.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int RATE_W          = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_in,
  output logic              btn_level,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic [RATE_W-1:0] rate_sel,
  output logic              long_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("btn_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_e;

  state_e            state_q, state_d;
  logic              s1_q, s2_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic [RATE_W-1:0] rate_q, rate_d;

`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  logic [HW-1:0] hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      rate_q    <= '0;
    end else begin
      s1_q      <= btn_in;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      rate_q    <= rate_d;
    end
  end

  // Every state change restarts the qualification count from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    press_d   = (state_q == PRESS_WAIT) && s2_q && (cnt_q == CNT_LAST);
    release_d = (state_q == RELEASE_WAIT) && !s2_q && (cnt_q == CNT_LAST);
    level_d   = level_q;
    if (press_d)   level_d = 1'b1;
    if (release_d) level_d = 1'b0;
`ifdef LONG_PRESS_EN
    // Saturating at LONG_CYCLES guarantees one long pulse per hold; bounces keep the count.
    long_d = 1'b0;
    hold_d = hold_q;
    if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
      if (hold_q == HOLD_LAST) begin
        long_d = 1'b1;
        hold_d = HOLD_SAT;
      end else if (hold_q != HOLD_SAT) begin
        hold_d = hold_q + HOLD_ONE;
      end
    end
    if (state_d == IDLE || state_d == PRESS_WAIT) hold_d = '0;
`else
    long_d = 1'b0;
`endif
    rate_d = rate_q + RATE_W'(press_d);
    if (long_d) rate_d = '0;
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign rate_sel      = rate_q;

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Front-end conditioning stage that feeds the LED blinker.
- Synchronises a raw asynchronous push-button and debounces it with a counter-qualified FSM.
- Emits clean level and edge pulses, plus a press-stepped blink-rate select that the blinker uses to choose which counter bit drives its LED.
- One clock domain; all outputs registered.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range >= 2
LONG_CYCLES, 100000000, cycles held after accepted press to flag a long press (1 s at 100 MHz); used only with LONG_PRESS_EN; >= 2
RATE_W, 2, width of rate_sel; wraps at 2**RATE_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; synchronous and active-high
btn_in  input  1  raw button, asynchronous, active-high, bouncing
btn_level  output  1  debounced button level
press_pulse  output  1  one-cycle pulse on accepted press
release_pulse  output  1  one-cycle pulse on accepted release
rate_sel  output  RATE_W  blink-rate index for downstream blinker; increments per accepted press
long_pulse  output  1  one-cycle pulse on long press (constant 0 without LONG_PRESS_EN)

Behaviour:
- Reset: synchronous, active-high, dominates every other event in the same cycle.
  - Reset state: sync flops = 0, FSM = IDLE, counters = 0, btn_level = 0, press/release/long pulses = 0, rate_sel = 0.
- Synchroniser: 2-flop chain s1 <= btn_in, s2 <= s1. FSM sees only s2, so btn_in reaches the FSM 2 cycles late.
- Debounce counter width: $clog2(DEBOUNCE_CYCLES+1). Counter is cleared on every state entry.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: s2=1 -> PRESS_WAIT, cnt=0; otherwise stay.
  - PRESS_WAIT:
    - s2=0 -> IDLE (bounce rejected; no pulse; rate_sel unchanged).
    - Else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED: btn_level<=1, press_pulse<=1 for one cycle, rate_sel<=rate_sel+1 (modulo 2**RATE_W; all-ones wraps to 0).
    - Else cnt++.
  - PRESSED: s2=0 -> RELEASE_WAIT, cnt=0; otherwise stay (hold counter runs, see Optional Feature).
  - RELEASE_WAIT:
    - s2=1 -> PRESSED (bounce rejected; btn_level stays 1; no pulse).
    - Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE: btn_level<=0, release_pulse<=1 for one cycle.
    - Else cnt++.
- Latency: with btn_in stable high from before rising edge E1, press_pulse is high in the cycle following edge E(DEBOUNCE_CYCLES+3). Release latency is identical.
- Pulses never overlap. Minimum spacing between press_pulse and release_pulse is DEBOUNCE_CYCLES+1 cycles.
- Any glitch shorter than DEBOUNCE_CYCLES cycles (after synchronisation) produces no output change.
- Reset while button is held:
  - FSM returns to IDLE and rate_sel returns to 0.
  - If btn_in is still high after reset releases, the button is re-qualified as a fresh press: press_pulse fires and rate_sel becomes 1.
- rate_sel changes only in the cycle press_pulse asserts (or as stated under Optional Feature).

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - A hold counter (width $clog2(LONG_CYCLES+1)) clears on entry to PRESSED and increments each cycle in PRESSED or RELEASE_WAIT.
  - When it reaches LONG_CYCLES-1: long_pulse<=1 for one cycle and rate_sel<=0; the counter then saturates, so there is at most one long_pulse per press.
  - The hold counter clears on return to IDLE.
  - A rejected release bounce does not clear the hold counter.
- Undefined: hold counter not instantiated; long_pulse tied to 0; rate_sel altered only by presses and reset.

Test Plan:
- DEBOUNCE_CYCLES=4. rst for 2 cycles, then btn_in=1 held -> press_pulse high exactly one cycle, after edge 7 counted from first edge sampling btn_in=1; btn_level 0->1 same cycle; rate_sel 0->1.
- Bounce rejection: btn_in pulses high 3 cycles, low 2, high 2, low (DEBOUNCE_CYCLES=4) -> no press_pulse; btn_level stays 0; rate_sel unchanged.
- Release: from pressed, btn_in=0 held -> release_pulse one cycle after 7 edges; btn_level 1->0. A 2-cycle low glitch while pressed -> no release_pulse.
- Wrap: 5 clean presses with RATE_W=2 -> rate_sel sequence 1,2,3,0,1.
- Reset mid-press: assert rst while PRESSED with rate_sel=2 and btn_in held -> all outputs 0 next cycle; after rst deasserts, press_pulse after 7 edges and rate_sel=1.
- LONG_PRESS_EN, DEBOUNCE_CYCLES=4, LONG_CYCLES=16, rate_sel=3: hold 30 cycles -> single long_pulse 16 cycles after press_pulse, rate_sel->0. Macro undefined -> long_pulse stays 0 throughout.
